bang_volume_ctrl: RTL

//  CPU-side producer of the 4-bit crash volume (crsh) consumed by bang_sound.

---
 rtl/bzone_sound_pkg.sv | 14 +
 rtl/bang_volume_ctrl_tick_divider.sv | 30 +++
 rtl/bang_volume_ctrl.sv | 93 +++++++++
 3 files changed

// File: rtl/bzone_sound_pkg.sv
// Shared types and constants for the Battlezone sound CPU interface.
package bzone_sound_pkg;

  typedef logic [3:0] vol_t;

  localparam logic [15:0] CRASH_ADDR_DEFAULT = 16'h1840;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DECAY = 2'd1,
    MUTED = 2'd2
  } bang_vol_state_t;

endpackage

// File: rtl/bang_volume_ctrl_tick_divider.sv
// Divides the 48 kHz strobe by SLEW_DIV; step_o pulses on the tick that
// completes each group of SLEW_DIV ticks.
module tick_divider #(
  parameter int SLEW_DIV = 240
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic tick_i,
  output logic step_o
);

  localparam int W = $clog2(SLEW_DIV + 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         wrap;

  assign wrap   = (cnt_q == W'(SLEW_DIV - 1));
  assign step_o = tick_i && wrap && !clr_i;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (tick_i) cnt_d = wrap ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bang_volume_ctrl.sv
// Crash volume producer: decodes CPU writes, attacks instantly and decays
// one step per SLEW_DIV 48 kHz ticks toward the written target.
//
// state | meaning
// IDLE  | crsh equals target (or was set directly)
// DECAY | crsh above target, stepping down on divider pulses
// MUTED | output forced to 0, target still tracks writes
module bang_volume_ctrl
  import bzone_sound_pkg::*;
#(
  parameter logic [15:0] CRASH_ADDR = CRASH_ADDR_DEFAULT,
  parameter int          SLEW_DIV   = 240
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en_48KHz,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_we,
  input  logic        mute,
  output logic [3:0]  crsh,
  output logic        busy
);

  bang_vol_state_t state_q, state_d;
  vol_t            crsh_q, crsh_d;
  vol_t            target_q, target_d;

  logic write_hit;
  logic step;
  logic div_clr;
  vol_t din_vol;
  logic unused_din;

  assign write_hit  = cpu_we && (cpu_addr == CRASH_ADDR);
  assign din_vol    = cpu_din[3:0];
  assign unused_din = ^cpu_din[6:4];

  // Any higher-priority event restarts the prescaler so the next step is a full period away.
  assign div_clr = rst || mute || write_hit || (state_q != DECAY);

  tick_divider #(.SLEW_DIV(SLEW_DIV)) u_div (
    .clk_i  (clk),
    .clr_i  (div_clr),
    .tick_i (clk_en_48KHz),
    .step_o (step)
  );

  always_comb begin
    state_d  = state_q;
    crsh_d   = crsh_q;
    target_d = target_q;
    if (write_hit) target_d = din_vol;

    if (mute) begin
      state_d = MUTED;
      crsh_d  = '0;
    end else if (state_q == MUTED) begin
      state_d = IDLE;
      crsh_d  = write_hit ? din_vol : target_q;
    end else if (write_hit) begin
      if ((din_vol >= crsh_q) || cpu_din[7]) begin
        crsh_d  = din_vol;
        state_d = IDLE;
      end else begin
        state_d = DECAY;
      end
    end else if ((state_q == DECAY) && step) begin
      if (crsh_q > target_q) begin
        crsh_d = crsh_q - 4'd1;
        if ((crsh_q - 4'd1) == target_q) state_d = IDLE;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      crsh_q   <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      crsh_q   <= crsh_d;
      target_q <= target_d;
    end
  end

  assign crsh = crsh_q;
  assign busy = (state_q == DECAY);

endmodule
